// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: state encoding and
// the default memory-wait timeout.
package pipeline_ctrl_pkg;

   typedef enum logic {
      StRun     = 1'b0,
      StMemWait = 1'b1
   } ctrl_state_e;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/perf_event_counter.sv
// Free-running event counter: increments on enable, synchronous clear,
// wraps at 2^CNT_W.
module perf_event_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// 5-stage pipeline stall/flush controller with memory-wait timeout detection.
// Define PIPE_PERF_CNT_EN to add the stall_cycles/flush_cycles counters.
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_stall,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_flush,
   output logic             mem_timeout_err
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
`endif
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

   if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
      $error("MEM_TIMEOUT and CNT_W must both be at least 1");
   end

   ctrl_state_e      state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;
   logic             freeze;

   assign freeze = dmem_req & ~dmem_ready;

   // Priority: reset > memory freeze > branch redirect > load-use stall.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      state_d      = StRun;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
         state_d      = StMemWait;
      end else if (branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (hazard_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // Counts MEM_WAIT cycles that stay frozen; the error latches the edge the
   // count reaches the limit, and the pipeline is never forced out of the wait.
   always_comb begin
      wait_cnt_d = '0;
      if (state_q == StMemWait && freeze) begin
         wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
      end
      err_d = err_q | (wait_cnt_d == WaitMax);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   assign mem_timeout_err = err_q;

`ifdef PIPE_PERF_CNT_EN
   logic stall_ev, flush_ev;

   assign stall_ev = ~rst & ~pc_write;
   assign flush_ev = ~rst & ~freeze & branch_taken;

   perf_event_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk    (clk),
      .clear  (rst),
      .enable (stall_ev),
      .count  (stall_cycles)
   );

   perf_event_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk    (clk),
      .clear  (rst),
      .enable (flush_ev),
      .count  (flush_cycles)
   );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller against a rule-level model.
// Perf-counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipeline_stall_controller;

   localparam int unsigned MT = 4;
   localparam int unsigned CW = 16;

   logic clk = 1'b0;
   logic rst, hazard_stall, branch_taken, dmem_req, dmem_ready;
   logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic ex_mem_write, mem_wb_flush, mem_timeout_err;
`ifdef PIPE_PERF_CNT_EN
   logic [CW-1:0] stall_cycles, flush_cycles;
`endif

   int checks = 0;
   int failures = 0;

   // Model state: expected outputs this cycle, frozen-run length, sticky error, counts.
   logic [6:0]    m_exp;
   logic          m_err = 1'b0;
   int            m_run = 0;
   logic [CW-1:0] m_stall = '0;
   logic [CW-1:0] m_flush = '0;

   wire [7:0] obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                     ex_mem_write, mem_wb_flush, mem_timeout_err};

   pipeline_stall_controller #(
      .MEM_TIMEOUT (MT),
      .CNT_W       (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .hazard_stall    (hazard_stall),
      .branch_taken    (branch_taken),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_write     (id_ex_write),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_write    (ex_mem_write),
      .mem_wb_flush    (mem_wb_flush),
      .mem_timeout_err (mem_timeout_err)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cycles    (stall_cycles),
      .flush_cycles    (flush_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Output order: pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f.
   function automatic logic [6:0] exp_out(input logic [4:0] v);
      logic r, h, b, q, y;
      {r, h, b, q, y} = v;
      if (r)           return 7'b0010101;
      if (q && !y)     return 7'b0000001;
      if (b)           return 7'b1111110;
      if (h)           return 7'b0001110;
      return 7'b1101010;
   endfunction

   // v = {rst, hazard_stall, branch_taken, dmem_req, dmem_ready}
   task automatic apply(input logic [4:0] v);
      {rst, hazard_stall, branch_taken, dmem_req, dmem_ready} = v;
      m_exp = exp_out(v);
      #3;
   endtask

   task automatic tick();
      logic frozen;
      @(posedge clk);
      frozen = dmem_req && !dmem_ready;
      if (rst) begin
         m_run = 0;
         m_err = 1'b0;
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (!m_exp[6]) m_stall = m_stall + 1'b1;
         if (branch_taken && !frozen) m_flush = m_flush + 1'b1;
         m_run = frozen ? m_run + 1 : 0;
         if (m_run > int'(MT)) m_err = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         apply({1'b1, 4'($urandom_range(0, 15))});
         checks++;
         if (obs !== {m_exp, 1'b0}) begin
            failures++;
            $display("FAIL reset cyc%0d: got=%b want=%b", i, obs, {m_exp, 1'b0});
         end
         tick();
      end
      apply(5'b00000);
      checks++;
      if (obs !== 8'b11010100) begin
         failures++;
         $display("FAIL reset_release: got=%b want=%b", obs, 8'b11010100);
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (stall_cycles !== '0 || flush_cycles !== '0) begin
         failures++;
         $display("FAIL reset_perf: got=%0d/%0d want=0/0", stall_cycles, flush_cycles);
      end
`endif
      tick();
   endtask

   task automatic test_hazard();
      logic [4:0] seq [3] = '{5'b01000, 5'b00000, 5'b01000};
      for (int i = 0; i < 3; i++) begin
         apply(seq[i]);
         checks++;
         if (obs !== {m_exp, m_err}) begin
            failures++;
            $display("FAIL hazard cyc%0d: got=%b want=%b", i, obs, {m_exp, m_err});
         end
         tick();
      end
   endtask

   task automatic test_branch_hazard();
      logic [4:0] seq [3] = '{5'b01100, 5'b00100, 5'b00000};
      for (int i = 0; i < 3; i++) begin
         apply(seq[i]);
         checks++;
         if (obs !== {m_exp, m_err}) begin
            failures++;
            $display("FAIL branch_hazard cyc%0d: got=%b want=%b", i, obs, {m_exp, m_err});
         end
         tick();
      end
   endtask

   task automatic test_mem_freeze();
      logic [4:0] seq [5] = '{5'b00010, 5'b00010, 5'b00010, 5'b00011, 5'b00000};
`ifdef PIPE_PERF_CNT_EN
      logic [CW-1:0] base = stall_cycles;
`endif
      for (int i = 0; i < 5; i++) begin
         apply(seq[i]);
         checks++;
         if (obs !== {m_exp, m_err}) begin
            failures++;
            $display("FAIL mem_freeze cyc%0d: got=%b want=%b", i, obs, {m_exp, m_err});
         end
         tick();
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (stall_cycles - base !== CW'(3)) begin
         failures++;
         $display("FAIL mem_freeze_stall_cnt: got=%0d want=3", stall_cycles - base);
      end
`endif
   endtask

   task automatic test_timeout();
      logic [4:0] seq [13] = '{5'b10000, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010,
                               5'b00010, 5'b00010, 5'b00011, 5'b00000, 5'b01000,
                               5'b10000, 5'b00000};
      for (int k = 0; k < 13; k++) begin
         apply(seq[k]);
         checks++;
         if (obs !== {m_exp, m_err}) begin
            failures++;
            $display("FAIL timeout cyc%0d: got=%b want=%b", k, obs, {m_exp, m_err});
         end
         // Five frozen edges (one in RUN, four in MEM_WAIT) precede the error.
         if (k == 5 || k == 6) begin
            checks++;
            if (mem_timeout_err !== (k == 6)) begin
               failures++;
               $display("FAIL timeout_edge cyc%0d: got=%b want=%b", k, mem_timeout_err, k == 6);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [4:0] seq [5] = '{5'b00010, 5'b00010, 5'b00010, 5'b10010, 5'b00000};
      for (int i = 0; i < 5; i++) begin
         apply(seq[i]);
         checks++;
         if (obs !== {m_exp, m_err}) begin
            failures++;
            $display("FAIL reset_mid_wait cyc%0d: got=%b want=%b", i, obs, {m_exp, m_err});
         end
         tick();
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (stall_cycles !== '0 || flush_cycles !== '0) begin
         failures++;
         $display("FAIL reset_mid_wait_perf: got=%0d/%0d want=0/0", stall_cycles, flush_cycles);
      end
`endif
   endtask

   task automatic test_freeze_branch();
      logic [4:0] seq [4] = '{5'b00110, 5'b00110, 5'b00111, 5'b00000};
      for (int i = 0; i < 4; i++) begin
         apply(seq[i]);
         checks++;
         if (obs !== {m_exp, m_err}) begin
            failures++;
            $display("FAIL freeze_branch cyc%0d: got=%b want=%b", i, obs, {m_exp, m_err});
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [4:0] v;
      for (int i = 0; i < 400; i++) begin
         v[4] = ($urandom_range(0, 99) < 3);
         v[3] = ($urandom_range(0, 99) < 30);
         v[2] = ($urandom_range(0, 99) < 20);
         v[1] = ($urandom_range(0, 99) < 35);
         v[0] = ($urandom_range(0, 99) < 45);
         apply(v);
         checks++;
         if (obs !== {m_exp, m_err}) begin
            failures++;
            $display("FAIL random cyc%0d in=%b: got=%b want=%b", i, v, obs, {m_exp, m_err});
         end
`ifdef PIPE_PERF_CNT_EN
         checks++;
         if (stall_cycles !== m_stall || flush_cycles !== m_flush) begin
            failures++;
            $display("FAIL random_perf cyc%0d: got=%0d/%0d want=%0d/%0d", i, stall_cycles,
                     flush_cycles, m_stall, m_flush);
         end
`endif
         tick();
      end
   endtask

   initial begin
      {rst, hazard_stall, branch_taken, dmem_req, dmem_ready} = 5'b10000;
      m_exp = exp_out(5'b10000);
      tick();
      test_reset();
      test_hazard();
      test_branch_hazard();
      test_mem_freeze();
      test_timeout();
      test_reset_mid_wait();
      test_freeze_branch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max consecutive MEM_WAIT cycles before error.
REQ-002 SHALL have parameter CNT_W, default 32: width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 hazard_stall  in  1  load-use stall request from hazard detection (ID vs EX).
REQ-006 branch_taken  in  1  EX-stage redirect (taken branch/jump).
REQ-007 dmem_req  in  1  MEM-stage data-memory access in progress.
REQ-008 dmem_ready  in  1  data memory completes access this cycle.
REQ-009 pc_write  out  1  PC register load enable.
REQ-010 if_id_write  out  1  IF/ID register load enable.
REQ-011 if_id_flush  out  1  IF/ID cleared to NOP.
REQ-012 id_ex_write  out  1  ID/EX register load enable.
REQ-013 id_ex_flush  out  1  ID/EX loaded with bubble (all control zero).
REQ-014 ex_mem_write  out  1  EX/MEM register load enable.
REQ-015 mem_wb_flush  out  1  MEM/WB loaded with bubble.
REQ-016 mem_timeout_err  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT.

Function
REQ-017 State register SHALL hold two states, RUN and MEM_WAIT; outputs SHALL be combinational from state and current inputs (same-cycle effect).
REQ-018 Default (RUN, no event): all *_write=1, all *_flush=0.
REQ-019 Priority SHALL be: memory freeze > branch_taken > hazard_stall.
REQ-020 Freeze (dmem_req=1, dmem_ready=0, either state): pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_flush=1, other flushes 0; next state MEM_WAIT.
REQ-021 MEM_WAIT with dmem_ready=1 or dmem_req=0: default outputs, then branch/stall rules of REQ-022/023 apply this cycle; next state RUN.
REQ-022 branch_taken (not frozen): pc_write=1, if_id_flush=1, id_ex_flush=1; hazard_stall ignored that cycle.
REQ-023 hazard_stall only (not frozen, no branch): pc_write=0, if_id_write=0, id_ex_flush=1; exactly one bubble per assertion cycle.
REQ-024 Flush and write of same register: flush SHALL take effect (write enable irrelevant).
REQ-025 Wait counter SHALL count consecutive MEM_WAIT cycles, clear on leaving MEM_WAIT, saturate at MEM_TIMEOUT.
REQ-026 When wait counter reaches MEM_TIMEOUT, mem_timeout_err SHALL set next edge and stay set until rst; pipeline stays frozen (no forced exit).

Reset
REQ-027 While rst=1: pc_write, if_id_write, id_ex_write, ex_mem_write =0; if_id_flush, id_ex_flush, mem_wb_flush =1.
REQ-028 On edge with rst=1: state=RUN, wait counter=0, mem_timeout_err=0, perf counters=0; rst mid-MEM_WAIT SHALL abandon wait.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN defined: outputs stall_cycles, flush_cycles (CNT_W each) present; stall_cycles +1 per cycle with pc_write=0; flush_cycles +1 per cycle with branch flush; wrap at 2^CNT_W.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 State encoding (RUN=0, MEM_WAIT=1) and default MEM_TIMEOUT SHALL live in shared package pipeline_ctrl_pkg.
REQ-032 Perf counters SHALL be one sub-module, perf_event_counter (enable, clear, CNT_W parameter), instantiated twice.

Verification
REQ-033 hazard_stall=1 one cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; defaults next cycle.
REQ-034 branch_taken=1 and hazard_stall=1 together -> pc_write=1, if_id_flush=1, id_ex_flush=1.
REQ-035 dmem_req=1, dmem_ready low 3 cycles then high -> 3 frozen cycles with mem_wb_flush=1, state RUN after ready edge; stall_cycles=3 (macro on).
REQ-036 MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout_err=1 after 4th wait cycle, stays 1 after ready; cleared only by rst.
REQ-037 rst=1 during MEM_WAIT -> flushes=1, writes=0; after rst release, state RUN, counters 0, default outputs.
REQ-038 Freeze while branch_taken=1 -> no flush until dmem_ready=1; branch flush applied on that cycle.
